i2s_ws_sequencer: RTL
=====================

Name: i2s_ws_sequencer

Overview:
- I2S master-side frame sequencer clocked on the bit clock `sck`.
- Generates word select (`ws`) for the I2S receive datapath.
- Knows when the receiver's `data_left`/`data_right` registers have settled, and captures each complete stereo frame into a single-entry valid/ready output buffer.
- Handles start/stop sequencing, frame counting and overrun accounting between the receiver and the downstream sample consumer.

Parameters:
- SLOT_BITS, 32, sck cycles per channel slot (legal 16..32); full frame = 2*SLOT_BITS.
- CAPTURE_DLY, 3, sck cycles from the sequencer's ws toggle edge to safe sampling of the receiver's `data_*` (receiver: 2-stage ws sync plus 1 capture edge).

Ports:
- sck  in  1  bit clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request, level sensitive.
- ovr_clr  in  1  single-cycle pulse; clears overrun status.
- data_left  in  32  left word from receiver.
- data_right  in  32  right word from receiver.
- ws  out  1  word select to receiver/codec; 0 = left slot.
- m_valid  out  1  output frame valid.
- m_ready  in  1  downstream accept.
- m_left  out  32  captured left sample.
- m_right  out  32  captured right sample.
- frame_cnt  out  16  delivered frames; wraps 0xFFFF->0.
- overrun  out  1  sticky: frame arrived while the buffer was still held.
- overrun_cnt  out  8  overrun events; saturates at 255.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0. State = IDLE, slot counter `bit_cnt` = 0, capture countdown idle, `prime` flag = 1.
- States:
  - IDLE: ws=0, bit_cnt=0. enable=1 -> SYNC next cycle.
  - SYNC: ws=1 for exactly SLOT_BITS cycles. Then ws toggles to 0 and the state moves to RUN. The receiver's right-capture triggered by this edge is junk and is never sampled.
  - RUN: bit_cnt counts 0..SLOT_BITS-1. At wrap, ws toggles on the same edge.
  - Rising ws = end of left slot; no action.
  - Falling ws = end of frame: load countdown = CAPTURE_DLY.
  - enable=0 sampled in RUN -> DRAIN.
  - DRAIN: identical to RUN until the next falling-ws toggle. Its capture completes, then -> IDLE with ws=0. enable is ignored until IDLE is reached; IDLE re-enters SYNC if enable=1.
- Capture: when the countdown reaches 1, the next edge samples `data_left`/`data_right`.
  - If `prime`=1: the frame is discarded and `prime` clears. `prime` is set again on every IDLE->SYNC.
  - Otherwise: the frame is delivered to the buffer.
- Buffer handshake:
  - Transfer occurs when m_valid && m_ready; m_valid drops next cycle unless a load coincides.
  - Load with buffer empty, or with a same-cycle transfer: m_left/m_right update, m_valid=1, frame_cnt+1.
  - Load while m_valid=1 && !m_ready: overrun event. overrun=1, overrun_cnt+1 (saturating). Data handling per the optional feature. frame_cnt is not incremented.
- ovr_clr clears overrun and overrun_cnt. If it coincides with an overrun event: overrun=1, overrun_cnt=1.
- m_valid/m_left/m_right are never cleared by enable changes; a held frame remains until accepted.
- Async reset mid-frame: immediate return to the reset values; ws drops to 0 asynchronously.
- Timing: frame output period = 2*SLOT_BITS cycles. Latency from falling-ws edge to m_valid = CAPTURE_DLY+1 cycles.

Optional Feature:
- Macro: I2S_WS_SEQ_OVR_DROP_EN.
- Defined: on overrun, the new frame is dropped and the held m_left/m_right/m_valid are unchanged.
- Undefined: on overrun, the new frame overwrites m_left/m_right and m_valid stays 1.
- Counters and flag behave identically in both builds.

Test Plan:
- Reset, enable=1, SLOT_BITS=32, m_ready=1:
  - ws low through IDLE, high 32 cycles (SYNC), then 32/32 toggling.
  - First frame discarded.
  - Second frame gives m_valid=1 for one cycle, 4 cycles after falling ws; m_left/m_right equal the driven data; frame_cnt=1.
- Drive data_left=0xA5A50000, data_right=0x5A5A0000, m_ready=1 continuously for 10 frames -> frame_cnt=9 (prime drop), no overrun.
- m_ready=0 for 3 frame periods -> overrun=1, overrun_cnt=2, m_valid held.
  - Macro defined: m_left = first held frame.
  - Macro undefined: m_left = latest frame.
- ovr_clr pulsed on the same cycle as an overrun event -> overrun=1, overrun_cnt=1.
- Deassert enable mid-left-slot -> current frame completes and is delivered, then ws=0, busy=0. Re-enable -> SYNC, with the first frame discarded again.
- Assert rst_n=0 mid-right-slot with m_valid=1 -> all outputs 0 immediately. After release, sequencing restarts from IDLE.

Source files
------------

// File: rtl/i2s_ws_sequencer.sv
// I2S master ws/frame sequencer with a single-entry valid/ready frame buffer.
// Build option I2S_WS_SEQ_OVR_DROP_EN: on overrun keep the held frame, drop the new one.
module i2s_ws_sequencer #(
   parameter int SLOT_BITS   = 32,
   parameter int CAPTURE_DLY = 3
) (
   input  logic        sck,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        ovr_clr,
   input  logic [31:0] data_left,
   input  logic [31:0] data_right,
   output logic        ws,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_left,
   output logic [31:0] m_right,
   output logic [15:0] frame_cnt,
   output logic        overrun,
   output logic [7:0]  overrun_cnt,
   output logic        busy
);

   localparam int BW = $clog2(SLOT_BITS);
   localparam int CW = $clog2(CAPTURE_DLY + 1);
   localparam logic [BW-1:0] LAST = BW'(SLOT_BITS - 1);
   localparam logic [CW-1:0] DLY  = CW'(CAPTURE_DLY);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [2:0] {IDLE, SYNC, RUN, DRAIN, FLUSH} state_t;

   state_t          state, state_nxt;
   logic [BW-1:0]   bit_cnt, bit_nxt;
   logic            ws_nxt;
   logic            fall;
   logic            start;
   logic [CW-1:0]   dly_cnt;
   logic            prime;
   logic            cap_vld;
   logic [31:0]     cap_left, cap_right;
   logic            sample;
   logic            accept;
   logic            ovr_ev;

   assign sample = (dly_cnt == ONE);
   assign accept = !m_valid || m_ready;
   assign ovr_ev = cap_vld && !accept;
   assign busy   = (state != IDLE);

   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ws      <= 1'b0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         ws      <= ws_nxt;
         bit_cnt <= bit_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ws_nxt    = ws;
      bit_nxt   = bit_cnt;
      fall      = 1'b0;
      start     = 1'b0;
      unique case (state)
         IDLE: begin
            ws_nxt  = 1'b0;
            bit_nxt = '0;
            if (enable) begin
               state_nxt = SYNC;
               ws_nxt    = 1'b1;
               start     = 1'b1;
            end
         end
         SYNC: begin
            bit_nxt = bit_cnt + 1'b1;
            if (bit_cnt == LAST) begin
               bit_nxt   = '0;
               ws_nxt    = 1'b0;
               state_nxt = RUN;
            end
         end
         RUN, DRAIN: begin
            bit_nxt = bit_cnt + 1'b1;
            if (state == RUN && !enable)
               state_nxt = DRAIN;
            if (bit_cnt == LAST) begin
               bit_nxt = '0;
               ws_nxt  = ~ws;
               fall    = ws;
               if (state == DRAIN && ws)
                  state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            ws_nxt  = 1'b0;
            bit_nxt = '0;
            // leave only once the last frame has reached the buffer
            if (dly_cnt == '0 && !cap_vld)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         dly_cnt   <= '0;
         prime     <= 1'b1;
         cap_vld   <= 1'b0;
         cap_left  <= '0;
         cap_right <= '0;
      end else begin
         cap_vld <= 1'b0;
         if (fall)
            dly_cnt <= DLY;
         else if (dly_cnt != '0)
            dly_cnt <= dly_cnt - 1'b1;
         if (start) begin
            prime <= 1'b1;
         end else if (sample) begin
            if (prime) begin
               prime <= 1'b0;
            end else begin
               cap_vld   <= 1'b1;
               cap_left  <= data_left;
               cap_right <= data_right;
            end
         end
      end
   end

   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         m_valid     <= 1'b0;
         m_left      <= '0;
         m_right     <= '0;
         frame_cnt   <= '0;
         overrun     <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         if (cap_vld && accept) begin
            m_left    <= cap_left;
            m_right   <= cap_right;
            m_valid   <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
         end else if (ovr_ev) begin
`ifndef I2S_WS_SEQ_OVR_DROP_EN
            m_left  <= cap_left;
            m_right <= cap_right;
`endif
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
         if (ovr_clr) begin
            overrun     <= ovr_ev;
            overrun_cnt <= {7'd0, ovr_ev};
         end else if (ovr_ev) begin
            overrun <= 1'b1;
            if (overrun_cnt != 8'hFF)
               overrun_cnt <= overrun_cnt + 1'b1;
         end
      end
   end

endmodule
